game_state: RTL

Round and scoring controller for the Frogger game. It sits directly downstream of the collision checker and consumes its death and win flags. It drives the round reset that restarts the frog and car movers, and it keeps lives, level and a two-digit BCD score for the seven-segment display. Its state code lets the VGA controller tint the screen during death, win and game-over phases.

---
 rtl/game_state.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_state.sv
// game_state: round and scoring controller for the Frogger game.
//
// This block consumes the death/win flags from the collision checker. It
// sequences the death and win pauses and drives the round reset that holds
// the frog and car movers at their start positions. It also keeps lives,
// level and a two-digit BCD score for the seven-segment display. Every
// output is a register or a decode of registers; no input reaches an output
// combinationally.
//
// Parameters:
//   START_LIVES     lives loaded at reset/restart (1..3)
//   MAX_LEVEL       level saturation value (1..15)
//   RESPAWN_CYCLES  length of the death/win pause in clk cycles (>= 1)
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   death_collision  in   frog overlaps a car (level, synchronous)
//   win_collision    in   frog reached goal row (level, synchronous)
//   restart          in   new-game request (level, synchronous)
//   round_reset      out  hold frog and cars at start positions
//   lives            out  remaining lives
//   level            out  current level, 1..MAX_LEVEL
//   score_tens       out  BCD tens digit
//   score_ones       out  BCD ones digit
//   game_over        out  high in OVER
//   state            out  phase code (0 PLAY, 1 DYING, 2 WINNING, 3 OVER)
//
// State table:
//   state   | meaning
//   PLAY    | normal play, collisions are acted on
//   DYING   | post-death pause, movers held
//   WINNING | post-win pause, movers held
//   OVER    | out of lives, waiting for restart

module game_state #(
  parameter int START_LIVES    = 3,
  parameter int MAX_LEVEL      = 9,
  parameter int RESPAWN_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       death_collision,
  input  logic       win_collision,
  input  logic       restart,
  output logic       round_reset,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int TW = $clog2(RESPAWN_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESPAWN_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0]    LEVEL_MAX  = 4'(MAX_LEVEL);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    DYING   = 2'd1,
    WINNING = 2'd2,
    OVER    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    tens_q,  tens_d;
  logic [3:0]    ones_q,  ones_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PLAY;
      lives_q <= LIVES_INIT;
      level_q <= 4'd1;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    timer_d = timer_q;

    // restart wins over everything in every state; it also clears the timer
    // so a later pause always starts from a full load.
    if (restart) begin
      state_d = PLAY;
      lives_d = LIVES_INIT;
      level_d = 4'd1;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (death_collision) begin
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            timer_d = TIMER_LOAD;
            state_d = DYING;
          end else if (win_collision) begin
            // BCD increment, saturating at 99
            if (ones_q != 4'd9) begin
              ones_d = ones_q + 4'd1;
            end else if (tens_q != 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end
            if (level_q < LEVEL_MAX) level_d = level_q + 4'd1;
            timer_d = TIMER_LOAD;
            state_d = WINNING;
          end
        end
        DYING, WINNING: begin
          // The pause covers timer values LOAD..0, i.e. RESPAWN_CYCLES cycles.
          if (timer_q == '0) begin
            if (state_q == DYING && lives_q == 2'd0) state_d = OVER;
            else                                     state_d = PLAY;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = PLAY;
      endcase
    end
  end

  assign round_reset = (state_q != PLAY);
  assign game_over   = (state_q == OVER);
  assign state       = state_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign score_tens  = tens_q;
  assign score_ones  = ones_q;

endmodule
